// File: rtl/pcie_ss_axis_pkg.sv
// PCIe SS sideband types shared by the FLR sequencer and its request FIFO.
package pcie_ss_axis_pkg;

   // Function identifier carried on the FLR sideband.
   typedef struct packed {
      logic        vf_active;
      logic [2:0]  pf;
      logic [10:0] vf;
   } t_flr_func;

   // FLR sideband beat: tvalid is a single-cycle pulse, no backpressure.
   typedef struct packed {
      logic      tvalid;
      t_flr_func tdata;
   } t_axis_pcie_flr;

   localparam int T_AXIS_PCIE_FLR_WIDTH = $bits(t_axis_pcie_flr);
   localparam int FLR_FUNC_WIDTH        = $bits(t_flr_func);

   // FLR sequencer FSM states.
   typedef enum logic [1:0] {
      FLR_IDLE,
      FLR_ASSERT,
      FLR_WAIT_ACK,
      FLR_RESP
   } t_flr_seq_state;

   // True when two function identifiers name the same function.
   function automatic logic flr_func_match(input t_flr_func a, input t_flr_func b);
      return a == b;
   endfunction

endpackage

// File: rtl/pcie_flr_req_fifo.sv
// Synchronous FIFO of FLR function identifiers. A push while full is
// accepted when a pop happens in the same cycle.
module pcie_flr_req_fifo
   import pcie_ss_axis_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [FLR_FUNC_WIDTH-1:0] push_data,
   input  logic                      pop,
   output logic [FLR_FUNC_WIDTH-1:0] pop_data,
   output logic                      full,
   output logic                      empty
);

   localparam int AW = $clog2(DEPTH);

   logic [FLR_FUNC_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]             wr_ptr;
   logic [AW-1:0]             rd_ptr;
   logic [AW:0]               count;
   logic                      wr_en;
   logic                      rd_en;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign rd_en    = pop && !empty;
   assign wr_en    = push && (!full || rd_en);
   assign pop_data = mem[rd_ptr];

   // Storage array; contents are don't-care while empty so it has no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap modulo DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pcie_flr_sequencer.sv
// Serialises PCIe FLR requests, drives one function reset at a time to the
// function-reset controller and returns a one-cycle FLR completion.
module pcie_flr_sequencer
   import pcie_ss_axis_pkg::*;
#(
   parameter int FIFO_DEPTH      = 8,
   parameter int RST_HOLD_CYCLES = 16,
   parameter int ACK_TIMEOUT     = 4096
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [T_AXIS_PCIE_FLR_WIDTH-1:0] i_flr_req,
   output logic                             o_func_rst_valid,
   output logic [$bits(t_flr_func)-1:0]     o_func_rst,
   input  logic                             i_func_rst_ack,
   output logic [T_AXIS_PCIE_FLR_WIDTH-1:0] o_flr_rsp,
   output logic                             o_busy,
   output logic                             o_ovf_err,
   output logic                             o_timeout_err
);

   localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
   localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

   t_flr_seq_state      state, state_n;
   t_flr_func           cur_func, cur_func_n;
   logic [HOLD_W-1:0]   hold_cnt, hold_n;
   logic [TO_W-1:0]     to_cnt, to_n;
   logic                ack_seen, ack_seen_n;
   logic                ovf_err, timeout_err;
   logic                timeout_hit;
   logic                rsp_valid;

   t_axis_pcie_flr      req;
   t_axis_pcie_flr      rsp;
   logic                in_service;
   logic                dup;
   logic                fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
   logic [FLR_FUNC_WIDTH-1:0] fifo_head;

   assign req        = i_flr_req;
   assign in_service = (state == FLR_ASSERT) || (state == FLR_WAIT_ACK);
   // A repeat FLR for the function already being reset joins the current sequence.
   assign dup        = req.tvalid && in_service && flr_func_match(req.tdata, cur_func);
   assign fifo_push  = req.tvalid && !dup && (!fifo_full || fifo_pop);
   assign fifo_drop  = req.tvalid && !dup && fifo_full && !fifo_pop;

   pcie_flr_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (req.tdata),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // State register and sequence bookkeeping; sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FLR_IDLE;
         cur_func    <= '0;
         hold_cnt    <= '0;
         to_cnt      <= '0;
         ack_seen    <= 1'b0;
         ovf_err     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         cur_func    <= cur_func_n;
         hold_cnt    <= hold_n;
         to_cnt      <= to_n;
         ack_seen    <= ack_seen_n;
         ovf_err     <= ovf_err | fifo_drop;
         timeout_err <= timeout_err | timeout_hit;
      end
   end

   // Next-state logic: pop, hold reset, wait for ack or timeout, respond.
   always_comb begin
      state_n     = state;
      cur_func_n  = cur_func;
      hold_n      = hold_cnt;
      to_n        = to_cnt;
      ack_seen_n  = ack_seen;
      fifo_pop    = 1'b0;
      timeout_hit = 1'b0;
      rsp_valid   = 1'b0;
      unique case (state)
         FLR_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               cur_func_n = fifo_head;
               hold_n     = '0;
               ack_seen_n = 1'b0;
               state_n    = FLR_ASSERT;
            end
         end
         FLR_ASSERT: begin
            hold_n     = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
            ack_seen_n = ack_seen | i_func_rst_ack;
            if (hold_cnt == HOLD_LAST) begin
               if (ack_seen || i_func_rst_ack) begin
                  state_n = FLR_RESP;
               end else begin
                  to_n    = '0;
                  state_n = FLR_WAIT_ACK;
               end
            end
         end
         FLR_WAIT_ACK: begin
            if (i_func_rst_ack) begin
               state_n = FLR_RESP;
            end else begin
               to_n = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
               if (to_cnt == TO_LAST) begin
                  timeout_hit = 1'b1;
                  state_n     = FLR_RESP;
               end
            end
         end
         FLR_RESP: begin
            rsp_valid = 1'b1;
            state_n   = FLR_IDLE;
         end
         default: state_n = FLR_IDLE;
      endcase
   end

   // Completion beat: tdata forced to zero outside the pulse.
   always_comb begin
      rsp.tvalid = rsp_valid;
      rsp.tdata  = rsp_valid ? cur_func : '0;
   end

   assign o_flr_rsp        = rsp;
   assign o_func_rst_valid = in_service;
   assign o_func_rst       = cur_func;
   assign o_busy           = (state != FLR_IDLE) || !fifo_empty;
   assign o_ovf_err        = ovf_err;
   assign o_timeout_err    = timeout_err;

endmodule

// File: tb/tb_pcie_flr_sequencer.sv
// Scoreboard bench for pcie_flr_sequencer: stimulus pushes expected
// completions, a negedge monitor pops and compares each response.
module tb_pcie_flr_sequencer;
   import pcie_ss_axis_pkg::*;

   localparam int HOLD  = 16;
   localparam int DEPTH = 8;
   localparam int TMO   = 64;

   logic                             clk = 1'b0;
   logic                             rst = 1'b1;
   logic [T_AXIS_PCIE_FLR_WIDTH-1:0] flr_req;
   logic                             ack;
   logic                             func_rst_valid;
   logic [$bits(t_flr_func)-1:0]     func_rst;
   logic [T_AXIS_PCIE_FLR_WIDTH-1:0] flr_rsp;
   logic                             busy;
   logic                             ovf_err;
   logic                             timeout_err;

   pcie_flr_sequencer #(
      .FIFO_DEPTH      (DEPTH),
      .RST_HOLD_CYCLES (HOLD),
      .ACK_TIMEOUT     (TMO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_flr_req        (flr_req),
      .o_func_rst_valid (func_rst_valid),
      .o_func_rst       (func_rst),
      .i_func_rst_ack   (ack),
      .o_flr_rsp        (flr_rsp),
      .o_busy           (busy),
      .o_ovf_err        (ovf_err),
      .o_timeout_err    (timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   // Cycle index: value seen after posedge k names the cycle that follows it.
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      t_flr_func func;
      int        at;   // expected cycle, -1 when not timed
   } exp_t;

   exp_t           sb[$];
   exp_t           e;
   t_axis_pcie_flr mon_r;
   int checks  = 0;
   int errors  = 0;
   int rsp_cnt = 0;
   int vcount  = 0;

   assign mon_r = flr_rsp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every response beat is matched against the scoreboard head.
   always @(negedge clk) begin
      if (!rst) begin
         if (func_rst_valid) vcount++;
         if (mon_r.tvalid) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp actual=%0h required=none", mon_r.tdata);
            end else begin
               e = sb.pop_front();
               chk("rsp_func", 32'(mon_r.tdata), 32'(e.func));
               if (e.at >= 0) chk("rsp_cycle", 32'(cyc), 32'(e.at));
            end
         end else begin
            chk("rsp_tdata_idle_zero", 32'(mon_r.tdata), 32'd0);
         end
      end
   end

   function automatic t_flr_func mk(input logic vfa, input logic [2:0] pf, input logic [10:0] vf);
      t_flr_func f;
      f.vf_active = vfa;
      f.pf        = pf;
      f.vf        = vf;
      return f;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input t_flr_func f);
      flr_req = {1'b1, f};
      step(1);
      flr_req = '0;
   endtask

   task automatic expect_rsp(input t_flr_func f, input int at);
      exp_t x;
      x.func = f;
      x.at   = at;
      sb.push_back(x);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         step(1);
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL %s_idle_timeout actual=busy required=idle", name);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int v0;
      int r0;
      t_flr_func f;

      flr_req = '0;
      ack     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid",   32'(func_rst_valid), 32'd0);
      chk("reset_func",    32'(func_rst),       32'd0);
      chk("reset_rsp",     32'(flr_rsp),        32'd0);
      chk("reset_busy",    32'(busy),           32'd0);
      chk("reset_ovf",     32'(ovf_err),        32'd0);
      chk("reset_timeout", 32'(timeout_err),    32'd0);
      step(1);
      rst = 1'b0;
      step(2);

      // Single request, ack held high: 16 valid cycles, completion at +18.
      ack = 1'b1;
      f   = mk(1'b0, 3'd1, 11'd0);
      c0  = cyc;
      v0  = vcount;
      expect_rsp(f, c0 + HOLD + 2);
      send(f);
      step(HOLD + 1);
      chk("t1_busy_at_rsp", 32'(busy), 32'd1);
      step(1);
      chk("t1_busy_after", 32'(busy), 32'd0);
      chk("t1_valid_cycles", 32'(vcount - v0), 32'(HOLD));
      chk("t1_func_held", 32'(func_rst), 32'(f));
      chk("t1_sb_drained", 32'(sb.size()), 32'd0);
      step(2);

      // Three back-to-back requests, completions every 18 cycles.
      c0 = cyc;
      for (int unsigned i = 0; i < 3; i++) expect_rsp(mk(1'b0, 3'(i), 11'd0), c0 + 18 * int'(i + 1));
      for (int unsigned i = 0; i < 3; i++) send(mk(1'b0, 3'(i), 11'd0));
      wait_idle("t2", 120);
      chk("t2_ovf", 32'(ovf_err), 32'd0);
      chk("t2_sb_drained", 32'(sb.size()), 32'd0);
      step(2);

      // Duplicate of the in-service function during WAIT_ACK is absorbed.
      ack = 1'b0;
      f   = mk(1'b1, 3'd0, 11'd5);
      c0  = cyc;
      r0  = rsp_cnt;
      expect_rsp(f, c0 + 26);
      send(f);
      step(19);
      send(f);
      chk("t4_fifo_count", 32'(dut.u_fifo.count), 32'd0);
      chk("t4_busy", 32'(busy), 32'd1);
      chk("t4_ovf", 32'(ovf_err), 32'd0);
      step(4);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      wait_idle("t4", 20);
      step(20);
      chk("t4_one_rsp", 32'(rsp_cnt - r0), 32'd1);
      chk("t4_sb_drained", 32'(sb.size()), 32'd0);

      // Overflow: 10 requests, 1 in service + 8 queued, the tenth dropped.
      for (int unsigned i = 1; i <= 9; i++) expect_rsp(mk(1'b0, 3'(i % 8), 11'(i)), -1);
      for (int unsigned i = 1; i <= 10; i++) send(mk(1'b0, 3'(i % 8), 11'(i)));
      chk("t3_ovf", 32'(ovf_err), 32'd1);
      chk("t3_fifo_full", 32'(dut.u_fifo.count), 32'(DEPTH));
      ack = 1'b1;
      wait_idle("t3", 9 * 20 + 40);
      chk("t3_sb_drained", 32'(sb.size()), 32'd0);
      chk("t3_timeout", 32'(timeout_err), 32'd0);
      chk("t3_ovf_sticky", 32'(ovf_err), 32'd1);
      ack = 1'b0;
      step(2);

      // Ack never arrives: completion 64 cycles after entering WAIT_ACK.
      f  = mk(1'b0, 3'd3, 11'd0);
      c0 = cyc;
      expect_rsp(f, c0 + HOLD + 2 + TMO);
      send(f);
      step(HOLD + TMO);
      chk("t5_timeout_before", 32'(timeout_err), 32'd0);
      step(1);
      chk("t5_timeout_set", 32'(timeout_err), 32'd1);
      wait_idle("t5", 10);
      ack = 1'b1;
      f   = mk(1'b0, 3'd4, 11'd0);
      expect_rsp(f, -1);
      send(f);
      wait_idle("t5b", 40);
      chk("t5_timeout_sticky", 32'(timeout_err), 32'd1);
      chk("t5_sb_drained", 32'(sb.size()), 32'd0);
      ack = 1'b0;
      step(2);

      // Async reset in WAIT_ACK with three queued: nothing completes.
      for (int unsigned i = 0; i < 4; i++) send(mk(1'b1, 3'd2, 11'(i + 20)));
      step(26);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_valid",   32'(func_rst_valid), 32'd0);
      chk("t6_func",    32'(func_rst),       32'd0);
      chk("t6_rsp",     32'(flr_rsp),        32'd0);
      chk("t6_busy",    32'(busy),           32'd0);
      chk("t6_ovf",     32'(ovf_err),        32'd0);
      chk("t6_timeout", 32'(timeout_err),    32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      r0  = rsp_cnt;
      step(40);
      chk("t6_no_rsp", 32'(rsp_cnt - r0), 32'd0);
      chk("t6_busy_after", 32'(busy), 32'd0);
      chk("t6_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
